// File: rtl/hrfp_round_pipe.sv
// HRFP_16 rounding stage, latency STAGES (1 or 2); define HRFP_ROUND_MODES_EN to decode RTZ/RUP/RDN from in_rm.
// The pipe advances as a whole when the output register is empty or out_ready=1; a stalled output holds its value.
module hrfp_round_pipe #(
  parameter int EXPBITS   = 8,
  parameter int PRECISION = 24,
  parameter int MANTBITS  = PRECISION + 3,
  parameter int STAGES    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXPBITS-1:0]  in_exp,
  input  logic [MANTBITS+1:0] in_mant,
  input  logic                in_sticky,
  input  logic                in_zero,
  input  logic [1:0]          in_rm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [EXPBITS-1:0]  out_exp,
  output logic [MANTBITS-1:0] out_mant,
  output logic                out_inexact,
  output logic                out_overflow
);

  localparam int TOP_DIGIT_LSB = PRECISION - 1;

  logic advance;

  logic [MANTBITS-1:0] f_m;
  logic [MANTBITS-1:0] f_masked;
  logic [1:0]          f_k;
  logic                f_lsb, f_r, f_s, f_inc, f_inexact;

  always_comb begin
    f_m   = in_mant[MANTBITS+1:2];
    f_k   = 2'd0;
    f_lsb = in_mant[2];
    f_r   = in_mant[1];
    f_s   = in_mant[0];
    // Keep width follows the leading one in the top hex digit.
    if (f_m[MANTBITS-1]) begin
      f_k   = 2'd3;
      f_lsb = in_mant[5];
      f_r   = in_mant[4];
      f_s   = |in_mant[3:0];
    end else if (f_m[MANTBITS-2]) begin
      f_k   = 2'd2;
      f_lsb = in_mant[4];
      f_r   = in_mant[3];
      f_s   = |in_mant[2:0];
    end else if (f_m[MANTBITS-3]) begin
      f_k   = 2'd1;
      f_lsb = in_mant[3];
      f_r   = in_mant[2];
      f_s   = |in_mant[1:0];
    end
    f_s       = f_s | in_sticky;
    f_masked  = f_m & ({MANTBITS{1'b1}} << f_k);
    f_inexact = f_r | f_s;
`ifdef HRFP_ROUND_MODES_EN
    case (in_rm)
      2'b00:   f_inc = f_r & (f_s | f_lsb);
      2'b01:   f_inc = 1'b0;
      2'b10:   f_inc = !in_sign & (f_r | f_s);
      default: f_inc = in_sign & (f_r | f_s);
    endcase
`else
    f_inc = f_r & (f_s | f_lsb);
`endif
  end

`ifndef HRFP_ROUND_MODES_EN
  logic unused_rm;
  assign unused_rm = ^in_rm;
`endif

  logic                a_vld_q, a_vld_d;
  logic                a_sign_q, a_sign_d;
  logic [EXPBITS-1:0]  a_exp_q, a_exp_d;
  logic                a_zero_q, a_zero_d;
  logic [1:0]          a_k_q, a_k_d;
  logic [MANTBITS-1:0] a_masked_q, a_masked_d;
  logic                a_inc_q, a_inc_d;
  logic                a_inexact_q, a_inexact_d;

  always_comb begin
    a_vld_d     = a_vld_q;
    a_sign_d    = a_sign_q;
    a_exp_d     = a_exp_q;
    a_zero_d    = a_zero_q;
    a_k_d       = a_k_q;
    a_masked_d  = a_masked_q;
    a_inc_d     = a_inc_q;
    a_inexact_d = a_inexact_q;
    if (advance) begin
      a_vld_d = in_valid;
      if (in_valid) begin
        a_sign_d    = in_sign;
        a_exp_d     = in_exp;
        a_zero_d    = in_zero;
        a_k_d       = f_k;
        a_masked_d  = f_masked;
        a_inc_d     = f_inc;
        a_inexact_d = f_inexact;
      end
    end
  end

  logic                b_vld, b_sign, b_zero, b_inc, b_inexact;
  logic [EXPBITS-1:0]  b_exp;
  logic [1:0]          b_k;
  logic [MANTBITS-1:0] b_masked;

  // With one stage the add consumes the decode directly; stage A registers are then dead.
  always_comb begin
    b_vld     = (STAGES == 2) ? a_vld_q     : in_valid;
    b_sign    = (STAGES == 2) ? a_sign_q    : in_sign;
    b_exp     = (STAGES == 2) ? a_exp_q     : in_exp;
    b_zero    = (STAGES == 2) ? a_zero_q    : in_zero;
    b_k       = (STAGES == 2) ? a_k_q       : f_k;
    b_masked  = (STAGES == 2) ? a_masked_q  : f_masked;
    b_inc     = (STAGES == 2) ? a_inc_q     : f_inc;
    b_inexact = (STAGES == 2) ? a_inexact_q : f_inexact;
  end

  logic [MANTBITS:0]   r_sum;
  logic                r_sign, r_inexact, r_overflow;
  logic [EXPBITS-1:0]  r_exp;
  logic [MANTBITS-1:0] r_mant;

  always_comb begin
    r_sum      = {1'b0, b_masked} + ({{MANTBITS{1'b0}}, b_inc} << b_k);
    r_sign     = b_sign;
    r_exp      = b_exp;
    r_mant     = r_sum[MANTBITS-1:0];
    r_inexact  = b_inexact;
    r_overflow = 1'b0;
    if (b_zero) begin
      r_exp     = '0;
      r_mant    = '0;
      r_inexact = 1'b0;
    end else if (r_sum[MANTBITS]) begin
      if (&b_exp) begin
        r_mant     = '0;
        r_overflow = 1'b1;
      end else begin
        r_exp  = b_exp + {{(EXPBITS-1){1'b0}}, 1'b1};
        r_mant = {{(MANTBITS-1){1'b0}}, 1'b1} << TOP_DIGIT_LSB;
      end
    end
  end

  logic                o_vld_q, o_vld_d;
  logic                o_sign_q, o_sign_d;
  logic [EXPBITS-1:0]  o_exp_q, o_exp_d;
  logic [MANTBITS-1:0] o_mant_q, o_mant_d;
  logic                o_inexact_q, o_inexact_d;
  logic                o_overflow_q, o_overflow_d;

  assign advance = !o_vld_q || out_ready;

  always_comb begin
    o_vld_d      = o_vld_q;
    o_sign_d     = o_sign_q;
    o_exp_d      = o_exp_q;
    o_mant_d     = o_mant_q;
    o_inexact_d  = o_inexact_q;
    o_overflow_d = o_overflow_q;
    if (advance) begin
      o_vld_d = b_vld;
      if (b_vld) begin
        o_sign_d     = r_sign;
        o_exp_d      = r_exp;
        o_mant_d     = r_mant;
        o_inexact_d  = r_inexact;
        o_overflow_d = r_overflow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld_q      <= 1'b0;
      a_sign_q     <= 1'b0;
      a_exp_q      <= '0;
      a_zero_q     <= 1'b0;
      a_k_q        <= '0;
      a_masked_q   <= '0;
      a_inc_q      <= 1'b0;
      a_inexact_q  <= 1'b0;
      o_vld_q      <= 1'b0;
      o_sign_q     <= 1'b0;
      o_exp_q      <= '0;
      o_mant_q     <= '0;
      o_inexact_q  <= 1'b0;
      o_overflow_q <= 1'b0;
    end else begin
      a_vld_q      <= a_vld_d;
      a_sign_q     <= a_sign_d;
      a_exp_q      <= a_exp_d;
      a_zero_q     <= a_zero_d;
      a_k_q        <= a_k_d;
      a_masked_q   <= a_masked_d;
      a_inc_q      <= a_inc_d;
      a_inexact_q  <= a_inexact_d;
      o_vld_q      <= o_vld_d;
      o_sign_q     <= o_sign_d;
      o_exp_q      <= o_exp_d;
      o_mant_q     <= o_mant_d;
      o_inexact_q  <= o_inexact_d;
      o_overflow_q <= o_overflow_d;
    end
  end

  assign in_ready     = advance;
  assign out_valid    = o_vld_q;
  assign out_sign     = o_sign_q;
  assign out_exp      = o_exp_q;
  assign out_mant     = o_mant_q;
  assign out_inexact  = o_inexact_q;
  assign out_overflow = o_overflow_q;

endmodule

// File: tb/tb_hrfp_round_pipe.sv
// Directed bench for hrfp_round_pipe: a 1-stage and a 2-stage instance share the input bus.
module tb_hrfp_round_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_sign, in_sticky, in_zero;
  logic [7:0]  in_exp;
  logic [28:0] in_mant;
  logic [1:0]  in_rm;
  logic        out_ready1, out_ready2;

  logic        in_ready1, out_valid1, out_sign1, out_inexact1, out_overflow1;
  logic [7:0]  out_exp1;
  logic [26:0] out_mant1;
  logic        in_ready2, out_valid2, out_sign2, out_inexact2, out_overflow2;
  logic [7:0]  out_exp2;
  logic [26:0] out_mant2;

  hrfp_round_pipe #(.EXPBITS(8), .PRECISION(24), .MANTBITS(27), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
    .in_zero(in_zero), .in_rm(in_rm), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sign(out_sign1), .out_exp(out_exp1), .out_mant(out_mant1),
    .out_inexact(out_inexact1), .out_overflow(out_overflow1)
  );

  hrfp_round_pipe #(.EXPBITS(8), .PRECISION(24), .MANTBITS(27), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
    .in_zero(in_zero), .in_rm(in_rm), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_sign(out_sign2), .out_exp(out_exp2), .out_mant(out_mant2),
    .out_inexact(out_inexact2), .out_overflow(out_overflow2)
  );

  typedef struct packed {
    logic        sg;
    logic [7:0]  ex;
    logic [28:0] mt;
    logic        st;
    logic        zr;
    logic [1:0]  rm;
    logic [37:0] res;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [38:0] cap1, cap2;
  logic        early2;

  function automatic vec_t mk(input logic sg, input logic [7:0] ex, input logic [28:0] mt,
                              input logic st, input logic zr, input logic [1:0] rm,
                              input logic rsg, input logic [7:0] rex, input logic [26:0] rmt,
                              input logic rinx, input logic rovf);
    mk = '{sg, ex, mt, st, zr, rm, {rsg, rex, rmt, rinx, rovf}};
  endfunction

  function automatic logic [38:0] obs1();
    return {out_valid1, out_sign1, out_exp1, out_mant1, out_inexact1, out_overflow1};
  endfunction

  function automatic logic [38:0] obs2();
    return {out_valid2, out_sign2, out_exp2, out_mant2, out_inexact2, out_overflow2};
  endfunction

  task automatic drive(input vec_t v);
    in_sign   = v.sg;
    in_exp    = v.ex;
    in_mant   = v.mt;
    in_sticky = v.st;
    in_zero   = v.zr;
    in_rm     = v.rm;
    in_valid  = 1'b1;
  endtask

  // Offer one transaction, capture both DUTs at their expected latencies.
  task automatic apply(input vec_t v);
    @(negedge clk);
    out_ready2 = 1'b1;
    drive(v);
    @(negedge clk);
    in_valid = 1'b0;
    cap1   = obs1();
    early2 = out_valid2;
    @(negedge clk);
    cap2 = obs2();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_sticky = 1'b0; in_zero = 1'b0; in_rm = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (obs1() !== 39'd0) begin n_bad++; $display("FAIL reset_out1: got %h want 0", obs1()); end
    n_cmp++;
    if (obs2() !== 39'd0) begin n_bad++; $display("FAIL reset_out2: got %h want 0", obs2()); end
    @(negedge clk);
    n_cmp++;
    if ({in_ready1, in_ready2} !== 2'b11) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 11", {in_ready1, in_ready2});
    end
  endtask

  task automatic test_rne();
    vec_t v[6];
    v[0] = mk(0, 8'h40, 29'h10000010, 0, 0, 2'b00, 0, 8'h40, 27'h4000000, 1, 0);
    v[1] = mk(0, 8'h40, 29'h10000030, 0, 0, 2'b00, 0, 8'h40, 27'h4000010, 1, 0);
    v[2] = mk(1, 8'h12, 29'h08000018, 0, 0, 2'b00, 1, 8'h12, 27'h2000008, 1, 0);
    v[3] = mk(0, 8'h07, 29'h04000004, 0, 0, 2'b00, 0, 8'h07, 27'h1000000, 1, 0);
    v[4] = mk(0, 8'h07, 29'h04000004, 1, 0, 2'b00, 0, 8'h07, 27'h1000002, 1, 0);
    v[5] = mk(1, 8'h33, 29'h10000000, 0, 0, 2'b00, 1, 8'h33, 27'h4000000, 0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(v[i]);
      n_cmp++;
      if (cap1 !== {1'b1, v[i].res}) begin
        n_bad++; $display("FAIL rne[%0d]_lat1: got %h want %h", i, cap1, {1'b1, v[i].res});
      end
      n_cmp++;
      if (early2 !== 1'b0) begin n_bad++; $display("FAIL rne[%0d]_early2: got %b want 0", i, early2); end
      n_cmp++;
      if (cap2 !== {1'b1, v[i].res}) begin
        n_bad++; $display("FAIL rne[%0d]_lat2: got %h want %h", i, cap2, {1'b1, v[i].res});
      end
    end
  endtask

  task automatic test_carry();
    vec_t v[2];
    v[0] = mk(0, 8'h40, 29'h1FFFFFF0, 0, 0, 2'b00, 0, 8'h41, 27'h0800000, 1, 0);
    v[1] = mk(0, 8'hFF, 29'h1FFFFFF0, 0, 0, 2'b00, 0, 8'hFF, 27'h0000000, 1, 1);
    for (int i = 0; i < 2; i++) begin
      apply(v[i]);
      n_cmp++;
      if (cap1 !== {1'b1, v[i].res}) begin
        n_bad++; $display("FAIL carry[%0d]_lat1: got %h want %h", i, cap1, {1'b1, v[i].res});
      end
      n_cmp++;
      if (cap2 !== {1'b1, v[i].res}) begin
        n_bad++; $display("FAIL carry[%0d]_lat2: got %h want %h", i, cap2, {1'b1, v[i].res});
      end
    end
  endtask

  task automatic test_k0_zero();
    vec_t v[2];
    v[0] = mk(0, 8'h40, 29'h02000003, 0, 0, 2'b00, 0, 8'h40, 27'h0800001, 1, 0);
    v[1] = mk(1, 8'h40, 29'h10000030, 1, 1, 2'b00, 1, 8'h00, 27'h0000000, 0, 0);
    for (int i = 0; i < 2; i++) begin
      apply(v[i]);
      n_cmp++;
      if (cap1 !== {1'b1, v[i].res}) begin
        n_bad++; $display("FAIL k0zero[%0d]_lat1: got %h want %h", i, cap1, {1'b1, v[i].res});
      end
      n_cmp++;
      if (cap2 !== {1'b1, v[i].res}) begin
        n_bad++; $display("FAIL k0zero[%0d]_lat2: got %h want %h", i, cap2, {1'b1, v[i].res});
      end
    end
  endtask

  task automatic test_modes();
    vec_t v[5];
`ifdef HRFP_ROUND_MODES_EN
    v[0] = mk(0, 8'h40, 29'h10000030, 0, 0, 2'b01, 0, 8'h40, 27'h4000008, 1, 0);
    v[1] = mk(0, 8'h40, 29'h10000001, 0, 0, 2'b10, 0, 8'h40, 27'h4000008, 1, 0);
    v[2] = mk(0, 8'h40, 29'h10000001, 0, 0, 2'b11, 0, 8'h40, 27'h4000000, 1, 0);
    v[3] = mk(1, 8'h40, 29'h10000001, 0, 0, 2'b11, 1, 8'h40, 27'h4000008, 1, 0);
    v[4] = mk(1, 8'h40, 29'h10000001, 0, 0, 2'b10, 1, 8'h40, 27'h4000000, 1, 0);
`else
    v[0] = mk(0, 8'h40, 29'h10000030, 0, 0, 2'b01, 0, 8'h40, 27'h4000010, 1, 0);
    v[1] = mk(0, 8'h40, 29'h10000001, 0, 0, 2'b10, 0, 8'h40, 27'h4000000, 1, 0);
    v[2] = mk(0, 8'h40, 29'h10000001, 0, 0, 2'b11, 0, 8'h40, 27'h4000000, 1, 0);
    v[3] = mk(1, 8'h40, 29'h10000001, 0, 0, 2'b11, 1, 8'h40, 27'h4000000, 1, 0);
    v[4] = mk(1, 8'h40, 29'h10000001, 0, 0, 2'b10, 1, 8'h40, 27'h4000000, 1, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      apply(v[i]);
      n_cmp++;
      if (cap1 !== {1'b1, v[i].res}) begin
        n_bad++; $display("FAIL modes[%0d]_lat1: got %h want %h", i, cap1, {1'b1, v[i].res});
      end
      n_cmp++;
      if (cap2 !== {1'b1, v[i].res}) begin
        n_bad++; $display("FAIL modes[%0d]_lat2: got %h want %h", i, cap2, {1'b1, v[i].res});
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t t0, t1, t2;
    t0 = mk(0, 8'h40, 29'h10000010, 0, 0, 2'b00, 0, 8'h40, 27'h4000000, 1, 0);
    t1 = mk(0, 8'h41, 29'h10000030, 0, 0, 2'b00, 0, 8'h41, 27'h4000010, 1, 0);
    t2 = mk(0, 8'h42, 29'h02000003, 0, 0, 2'b00, 0, 8'h42, 27'h0800001, 1, 0);
    @(negedge clk);
    out_ready2 = 1'b0;
    n_cmp++;
    if (in_ready2 !== 1'b1) begin n_bad++; $display("FAIL bp_accept0: got %b want 1", in_ready2); end
    drive(t0);
    @(negedge clk);
    n_cmp++;
    if (in_ready2 !== 1'b1) begin n_bad++; $display("FAIL bp_accept1: got %b want 1", in_ready2); end
    drive(t1);
    @(negedge clk);
    drive(t2);
    n_cmp++;
    if (in_ready2 !== 1'b0) begin n_bad++; $display("FAIL bp_block2: got %b want 0", in_ready2); end
    n_cmp++;
    if (obs2() !== {1'b1, t0.res}) begin
      n_bad++; $display("FAIL bp_head: got %h want %h", obs2(), {1'b1, t0.res});
    end
    @(negedge clk);
    n_cmp++;
    if (obs2() !== {1'b1, t0.res} || in_ready2 !== 1'b0) begin
      n_bad++; $display("FAIL bp_hold: got %h/%b want %h/0", obs2(), in_ready2, {1'b1, t0.res});
    end
    out_ready2 = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (obs2() !== {1'b1, t1.res}) begin
      n_bad++; $display("FAIL bp_second: got %h want %h", obs2(), {1'b1, t1.res});
    end
    @(negedge clk);
    n_cmp++;
    if (obs2() !== {1'b1, t2.res}) begin
      n_bad++; $display("FAIL bp_third: got %h want %h", obs2(), {1'b1, t2.res});
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid2 !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", out_valid2); end
  endtask

  task automatic test_reset_stall();
    vec_t t0;
    t0 = mk(0, 8'h40, 29'h10000030, 0, 0, 2'b00, 0, 8'h40, 27'h4000010, 1, 0);
    @(negedge clk);
    out_ready2 = 1'b0;
    drive(t0);
    @(negedge clk);
    t0.mt = 29'h10000010;
    drive(t0);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid2 !== 1'b1) begin n_bad++; $display("FAIL rst_stall_full: got %b want 1", out_valid2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({out_valid1, out_valid2} !== 2'b00) begin
      n_bad++; $display("FAIL rst_stall_cleared: got %b want 00", {out_valid1, out_valid2});
    end
    out_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid2 !== 1'b0) begin
        n_bad++; $display("FAIL rst_stall_quiet[%0d]: got %b want 0", i, out_valid2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rne();
    test_carry();
    test_k0_zero();
    test_modes();
    test_back_to_back();
    test_reset_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
